// File: rtl/prog_loader_pkg.sv
// Shared CPU constants and the program-loader state encoding.
package prog_loader_pkg;

  // Instruction-memory geometry, common with the instruction memory itself.
  localparam int ADDR_W = 19;
  localparam int DATA_W = 19;

  // Three serial bytes make up one 19-bit instruction word.
  localparam int BYTES_PER_WORD = 3;
  localparam int IDX_W          = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } ld_state_e;

endpackage

// File: rtl/prog_loader_word_packer.sv
// Byte-index counter and 19-bit word assembly register with format check.
// Bytes arrive little-endian; only bits [2:0] of the third byte are kept.
module prog_loader_word_packer
  import prog_loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_i,
  output logic              word_valid_o,
  output logic              fmt_err_o,
  output logic [DATA_W-1:0] word_o
);

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              last_byte;

  assign last_byte = (idx_q == IDX_W'(BYTES_PER_WORD - 1));

  // Word completes on the edge that accepts the third byte; flag stray high bits.
  assign word_valid_o = byte_valid_i && last_byte && !clear_i;
  assign fmt_err_o    = word_valid_o && (byte_i[7:3] != 5'd0);
  assign word_o       = word_q;

  // Next-state for the byte index and the assembly register.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    idx_d  = idx_q;
    word_d = word_q;
    if (clear_i) begin
      idx_d = '0;
    end else if (byte_valid_i) begin
      case (idx_q)
        2'd0:    word_d[7:0]   = byte_i;
        2'd1:    word_d[15:8]  = byte_i;
        default: word_d[18:16] = byte_i[2:0];
      endcase
      idx_d = last_byte ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Index and assembly registers; reset discards any partial word.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst_i) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Byte-serial program loader: packs byte triples into 19-bit words and writes
// them to consecutive instruction-memory addresses, holding the CPU off meanwhile.
module prog_loader #(
  parameter int ADDR_W = prog_loader_pkg::ADDR_W,
  parameter int DATA_W = prog_loader_pkg::DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W-1:0] word_count_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  output logic              rx_ready_o,
  output logic              im_we_o,
  output logic [ADDR_W-1:0] im_addr_o,
  output logic [DATA_W-1:0] im_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_fmt_o
);

  import prog_loader_pkg::ld_state_e;
  import prog_loader_pkg::ST_IDLE;
  import prog_loader_pkg::ST_RECV;
  import prog_loader_pkg::ST_WRITE;
  import prog_loader_pkg::ST_DONE;

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic              err_q, err_d;

  logic              start_acc;
  logic              byte_acc;
  logic              word_valid;
  logic              fmt_err;
  logic [DATA_W-1:0] word;

  // rx_ready is decoded from state only, so no path from rx_valid back to rx_ready.
  assign start_acc = (state_q == ST_IDLE) && start_i;
  assign byte_acc  = (state_q == ST_RECV) && rx_valid_i;

  prog_loader_word_packer u_word_packer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (start_acc),
    .byte_valid_i (byte_acc),
    .byte_i       (rx_data_i),
    .word_valid_o (word_valid),
    .fmt_err_o    (fmt_err),
    .word_o       (word)
  );

  // Next-state, address/count/error update and output decode.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    count_d    = count_q;
    err_d      = err_q;
    rx_ready_o = 1'b0;
    im_we_o    = 1'b0;
    im_addr_o  = '0;
    im_data_o  = '0;
    busy_o     = 1'b0;
    done_o     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          addr_d  = base_addr_i;
          count_d = word_count_i;
          err_d   = 1'b0;
          state_d = (word_count_i != '0) ? ST_RECV : ST_DONE;
        end
      end
      ST_RECV: begin
        rx_ready_o = 1'b1;
        busy_o     = 1'b1;
        if (fmt_err)    err_d   = 1'b1;
        if (word_valid) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        busy_o    = 1'b1;
        im_we_o   = 1'b1;
        im_addr_o = addr_q;
        im_data_o = word;
        addr_d    = addr_q + ADDR_W'(1);
        count_d   = count_q - ADDR_W'(1);
        state_d   = (count_q == ADDR_W'(1)) ? ST_DONE : ST_RECV;
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign err_fmt_o = err_q;

  // State, address, count and sticky error registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [18:0] base_addr;
  logic [18:0] word_count;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        im_we;
  logic [18:0] im_addr;
  logic [18:0] im_data;
  logic        busy;
  logic        done;
  logic        err_fmt;

  int n_cmp = 0;
  int n_err = 0;

  // Write/done monitor state.
  int          cyc = 0;
  logic [18:0] wr_addr[$];
  logic [18:0] wr_data[$];
  int          wr_cyc[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          idle_viol = 0;
  int          busy_drop = 0;
  logic        in_load = 1'b0;

  always #5 clk = ~clk;

  prog_loader dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .base_addr_i  (base_addr),
    .word_count_i (word_count),
    .rx_valid_i   (rx_valid),
    .rx_data_i    (rx_data),
    .rx_ready_o   (rx_ready),
    .im_we_o      (im_we),
    .im_addr_o    (im_addr),
    .im_data_o    (im_data),
    .busy_o       (busy),
    .done_o       (done),
    .err_fmt_o    (err_fmt)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Sample outputs mid-cycle and log writes and done pulses.
  always @(negedge clk) begin
    if (im_we) begin
      wr_addr.push_back(im_addr);
      wr_data.push_back(im_data);
      wr_cyc.push_back(cyc);
    end else if (im_addr != 19'd0 || im_data != 19'd0) begin
      idle_viol <= idle_viol + 1;
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (in_load && !busy) busy_drop <= busy_drop + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    rx_valid = 1'b0;
    repeat (gap) tick();
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (!rx_ready && n < 20) begin
      tick();
      n++;
    end
    check("rx_ready_wait", {31'd0, rx_ready}, 32'd1);
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_done();
    int s;
    int n;
    s = done_cnt;
    n = 0;
    while (done_cnt == s && n < 60) begin
      tick();
      n++;
    end
    check("done_wait", {31'd0, done_cnt != s}, 32'd1);
  endtask

  task automatic pulse_start(input logic [18:0] ba, input logic [18:0] wc);
    base_addr  = ba;
    word_count = wc;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  initial begin
    int d0;
    rst = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
    rx_valid = 1'b0; rx_data = '0;

    // Reset for two cycles: every output low.
    tick(); tick();
    check("rst_outputs", {18'd0, rx_ready, im_we, im_addr != 19'd0, im_data != 19'd0,
                          busy, done, err_fmt, 7'd0}, 32'd0);
    rst = 1'b0;
    tick(); tick();
    check("idle_no_ready", {31'd0, rx_ready}, 32'd0);
    check("idle_no_busy",  {31'd0, busy}, 32'd0);

    // Two-word load, no gaps.
    clear_log();
    d0 = done_cnt;
    pulse_start(19'h00010, 19'd2);
    check("start_busy",  {31'd0, busy}, 32'd1);
    check("start_ready", {31'd0, rx_ready}, 32'd1);
    send_byte(8'h34, 0); send_byte(8'h12, 0); send_byte(8'h05, 0);
    check("write_we",    {31'd0, im_we}, 32'd1);
    check("write_ready", {31'd0, rx_ready}, 32'd0);
    check("write_addr",  {13'd0, im_addr}, 32'h00010);
    check("write_data",  {13'd0, im_data}, 32'h51234);
    send_byte(8'h78, 0); send_byte(8'h56, 0); send_byte(8'h02, 0);
    wait_done();
    check("a_nwrites", wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      check("a_addr0", {13'd0, wr_addr[0]}, 32'h00010);
      check("a_data0", {13'd0, wr_data[0]}, 32'h51234);
      check("a_addr1", {13'd0, wr_addr[1]}, 32'h00011);
      check("a_data1", {13'd0, wr_data[1]}, 32'h25678);
      check("a_spacing", wr_cyc[1] - wr_cyc[0], 4);
      check("a_done_cyc", done_cyc, wr_cyc[1] + 1);
    end
    check("a_done_once", done_cnt - d0, 1);
    check("a_err", {31'd0, err_fmt}, 32'd0);
    tick();
    check("a_done_pulse", {31'd0, done}, 32'd0);
    check("a_busy_low", {31'd0, busy}, 32'd0);

    // Same load with random rx_valid gaps.
    clear_log();
    d0 = done_cnt;
    pulse_start(19'h00010, 19'd2);
    in_load = 1'b1;
    send_byte(8'h34, $urandom_range(0, 3)); send_byte(8'h12, $urandom_range(0, 3));
    send_byte(8'h05, $urandom_range(0, 3)); send_byte(8'h78, $urandom_range(0, 3));
    send_byte(8'h56, $urandom_range(0, 3)); send_byte(8'h02, $urandom_range(0, 3));
    in_load = 1'b0;
    wait_done();
    check("b_nwrites", wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      check("b_addr0", {13'd0, wr_addr[0]}, 32'h00010);
      check("b_data0", {13'd0, wr_data[0]}, 32'h51234);
      check("b_addr1", {13'd0, wr_addr[1]}, 32'h00011);
      check("b_data1", {13'd0, wr_data[1]}, 32'h25678);
    end
    check("b_busy_held", busy_drop, 0);
    check("b_done_once", done_cnt - d0, 1);

    // Format error: high bits in byte2 set sticky err_fmt, word still written.
    clear_log();
    pulse_start(19'h00020, 19'd1);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'hFD, 0);
    check("c_err_set", {31'd0, err_fmt}, 32'd1);
    wait_done();
    tick(); tick(); tick();
    check("c_err_sticky", {31'd0, err_fmt}, 32'd1);
    check("c_nwrites", wr_addr.size(), 1);
    if (wr_addr.size() == 1) begin
      check("c_addr", {13'd0, wr_addr[0]}, 32'h00020);
      check("c_data", {13'd0, wr_data[0]}, 32'h52211);
    end

    // Zero-word load: clears err_fmt, done the cycle after start, no write.
    clear_log();
    d0 = done_cnt;
    pulse_start(19'h00055, 19'd0);
    check("d_err_clr", {31'd0, err_fmt}, 32'd0);
    check("d_done", {31'd0, done}, 32'd1);
    check("d_busy", {31'd0, busy}, 32'd0);
    tick();
    check("d_done_end", {31'd0, done}, 32'd0);
    tick();
    check("d_nwrites", wr_addr.size(), 0);
    check("d_done_once", done_cnt - d0, 1);

    // Address wrap; a start pulse mid-load must be ignored.
    clear_log();
    d0 = done_cnt;
    pulse_start(19'h7FFFF, 19'd2);
    send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    base_addr = 19'h00100; word_count = 19'd5; start = 1'b1;
    send_byte(8'h02, 0);
    start = 1'b0;
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    wait_done();
    tick(); tick();
    check("e_nwrites", wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      check("e_addr0", {13'd0, wr_addr[0]}, 32'h7FFFF);
      check("e_data0", {13'd0, wr_data[0]}, 32'h00001);
      check("e_addr1", {13'd0, wr_addr[1]}, 32'h00000);
      check("e_data1", {13'd0, wr_data[1]}, 32'h00002);
    end
    check("e_done_once", done_cnt - d0, 1);
    check("e_idle", {31'd0, busy}, 32'd0);

    // Reset after two bytes: no write, no done; a fresh load starts at byte0.
    clear_log();
    d0 = done_cnt;
    pulse_start(19'h00030, 19'd1);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    rst = 1'b1;
    tick(); tick();
    check("f_rst_busy", {31'd0, busy}, 32'd0);
    check("f_rst_ready", {31'd0, rx_ready}, 32'd0);
    rst = 1'b0;
    tick();
    check("f_no_write", wr_addr.size(), 0);
    check("f_no_done", done_cnt - d0, 0);
    pulse_start(19'h00040, 19'd1);
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0);
    wait_done();
    check("f_nwrites", wr_addr.size(), 1);
    if (wr_addr.size() == 1) begin
      check("f_addr", {13'd0, wr_addr[0]}, 32'h00040);
      check("f_data", {13'd0, wr_data[0]}, 32'h30201);
    end

    check("idle_addr_data_zero", idle_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
